// File: rtl/rvfi_reg_trace_driver_if.sv
// Record-in / RVFI-out bundle for rvfi_reg_trace_driver.
// master = record source and packet sink, slave = the driver.
interface rvfi_reg_trace_driver_if #(
    parameter int unsigned XLEN = 32
);
    logic                  in_valid;
    logic                  in_ready;
    logic [31:0]           in_insn;
    logic [4:0]            in_rs1;
    logic [4:0]            in_rs2;
    logic [4:0]            in_rd;
    logic [XLEN-1:0]       in_rd_wdata;
    logic                  in_pc_valid;
    logic [XLEN-1:0]       in_pc;
    logic                  in_jump;
    logic [XLEN-1:0]       in_target;
    logic                  in_trap;

    logic                  rvfi_valid;
    logic [7:0]            rvfi_order;
    logic [31:0]           rvfi_insn;
    logic [4:0]            rvfi_rs1_addr;
    logic [4:0]            rvfi_rs2_addr;
    logic [4:0]            rvfi_rd;
    logic [XLEN-1:0]       rvfi_pre_pc;
    logic [XLEN-1:0]       rvfi_pre_rs1;
    logic [XLEN-1:0]       rvfi_pre_rs2;
    logic [XLEN-1:0]       rvfi_post_pc;
    logic [XLEN-1:0]       rvfi_post_rd;
    logic                  rvfi_trap;
    logic [XLEN-1:0]       rvfi_mem_addr;
    logic [XLEN-1:0]       rvfi_mem_rdata;
    logic [XLEN-1:0]       rvfi_mem_wdata;
    logic [XLEN/8-1:0]     rvfi_mem_rmask;
    logic [XLEN/8-1:0]     rvfi_mem_wmask;

    modport master (
        output in_valid, in_insn, in_rs1, in_rs2, in_rd, in_rd_wdata,
               in_pc_valid, in_pc, in_jump, in_target, in_trap,
        input  in_ready,
        input  rvfi_valid, rvfi_order, rvfi_insn, rvfi_rs1_addr, rvfi_rs2_addr,
               rvfi_rd, rvfi_pre_pc, rvfi_pre_rs1, rvfi_pre_rs2, rvfi_post_pc,
               rvfi_post_rd, rvfi_trap, rvfi_mem_addr, rvfi_mem_rdata,
               rvfi_mem_wdata, rvfi_mem_rmask, rvfi_mem_wmask
    );

    modport slave (
        input  in_valid, in_insn, in_rs1, in_rs2, in_rd, in_rd_wdata,
               in_pc_valid, in_pc, in_jump, in_target, in_trap,
        output in_ready,
        output rvfi_valid, rvfi_order, rvfi_insn, rvfi_rs1_addr, rvfi_rs2_addr,
               rvfi_rd, rvfi_pre_pc, rvfi_pre_rs1, rvfi_pre_rs2, rvfi_post_pc,
               rvfi_post_rd, rvfi_trap, rvfi_mem_addr, rvfi_mem_rdata,
               rvfi_mem_wdata, rvfi_mem_rmask, rvfi_mem_wmask
    );
endinterface

// File: rtl/rvfi_reg_trace_driver.sv
// RVFI retirement driver: abstract records in, register-consistent RVFI packets out.
// Optional RVFI_DRIVER_FAULT_EN adds the fault_inj port for checker self-test.
module rvfi_reg_trace_driver #(
    parameter int unsigned XLEN     = 32,
    parameter logic [63:0] RESET_PC = '0
) (
    input  logic clk,
    input  logic reset,
`ifdef RVFI_DRIVER_FAULT_EN
    input  logic [1:0] fault_inj,
`endif
    rvfi_reg_trace_driver_if.slave bus
);
    typedef enum logic {CLEAR, RUN} state_t;

    state_t            state;
    logic [4:0]        clr_idx;
    logic [XLEN-1:0]   pc_q;
    logic [7:0]        order_q;
    logic [XLEN-1:0]   rf [32];

    logic              accept;
    logic              rd_wr;
    logic              rf_we;
    logic [1:0]        fault_sel;
    logic [XLEN-1:0]   pre_pc;
    logic [XLEN-1:0]   post_pc;
    logic [XLEN-1:0]   rs1_val;
    logic [XLEN-1:0]   rs2_val;

`ifdef RVFI_DRIVER_FAULT_EN
    assign fault_sel = fault_inj;
`else
    assign fault_sel = 2'd0;
`endif

    assign bus.in_ready = (state == RUN);
    assign accept       = bus.in_valid && (state == RUN);

    always_comb begin
        pre_pc  = bus.in_pc_valid ? bus.in_pc : pc_q;
        rs1_val = (bus.in_rs1 == 5'd0) ? '0 : rf[bus.in_rs1];
        rs2_val = (bus.in_rs2 == 5'd0) ? '0 : rf[bus.in_rs2];
        rs1_val[0] = rs1_val[0] ^ ((fault_sel == 2'd1) && (bus.in_rs1 != 5'd0));
        rs2_val[0] = rs2_val[0] ^ ((fault_sel == 2'd2) && (bus.in_rs2 != 5'd0));
        rd_wr   = !bus.in_trap && (bus.in_rd != 5'd0);
        // Mode 3 still reports the write on RVFI but leaves the RF untouched.
        rf_we   = rd_wr && (fault_sel != 2'd3);
        if (bus.in_jump)
            post_pc = bus.in_target;
        else if (bus.in_trap)
            post_pc = pre_pc;
        else if (bus.in_insn[1:0] != 2'b11)
            post_pc = pre_pc + XLEN'(2);
        else
            post_pc = pre_pc + XLEN'(4);
    end

    // Register file has no reset of its own; CLEAR walks it to zero.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state == CLEAR)
                rf[clr_idx] <= '0;
            else if (accept && rf_we)
                rf[bus.in_rd] <= bus.in_rd_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state             <= CLEAR;
            clr_idx           <= '0;
            pc_q              <= RESET_PC[XLEN-1:0];
            order_q           <= '0;
            bus.rvfi_valid    <= 1'b0;
            bus.rvfi_order    <= '0;
            bus.rvfi_insn     <= '0;
            bus.rvfi_rs1_addr <= '0;
            bus.rvfi_rs2_addr <= '0;
            bus.rvfi_rd       <= '0;
            bus.rvfi_pre_pc   <= '0;
            bus.rvfi_pre_rs1  <= '0;
            bus.rvfi_pre_rs2  <= '0;
            bus.rvfi_post_pc  <= '0;
            bus.rvfi_post_rd  <= '0;
            bus.rvfi_trap     <= 1'b0;
        end else begin
            bus.rvfi_valid <= accept;
            if (state == CLEAR) begin
                clr_idx <= clr_idx + 5'd1;
                if (clr_idx == 5'd31)
                    state <= RUN;
            end else if (accept) begin
                bus.rvfi_order    <= order_q;
                bus.rvfi_insn     <= bus.in_insn;
                bus.rvfi_rs1_addr <= bus.in_rs1;
                bus.rvfi_rs2_addr <= bus.in_rs2;
                bus.rvfi_rd       <= rd_wr ? bus.in_rd : 5'd0;
                bus.rvfi_pre_pc   <= pre_pc;
                bus.rvfi_pre_rs1  <= rs1_val;
                bus.rvfi_pre_rs2  <= rs2_val;
                bus.rvfi_post_pc  <= post_pc;
                bus.rvfi_post_rd  <= rd_wr ? bus.in_rd_wdata : '0;
                bus.rvfi_trap     <= bus.in_trap;
                pc_q              <= post_pc;
                order_q           <= order_q + 8'd1;
            end
        end
    end

    assign bus.rvfi_mem_addr  = '0;
    assign bus.rvfi_mem_rdata = '0;
    assign bus.rvfi_mem_wdata = '0;
    assign bus.rvfi_mem_rmask = '0;
    assign bus.rvfi_mem_wmask = '0;
endmodule

// File: tb/tb_rvfi_reg_trace_driver.sv
// Directed self-checking bench for rvfi_reg_trace_driver (RESET_PC = 0x100).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_rvfi_reg_trace_driver;
    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_err = 0;

`ifdef RVFI_DRIVER_FAULT_EN
    logic [1:0] fault_inj;
`endif

    rvfi_reg_trace_driver_if #(.XLEN(32)) bus ();

    rvfi_reg_trace_driver #(
        .XLEN     (32),
        .RESET_PC (64'h100)
    ) dut (
        .clk       (clk),
        .reset     (reset),
`ifdef RVFI_DRIVER_FAULT_EN
        .fault_inj (fault_inj),
`endif
        .bus       (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [31:0] insn, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [4:0] rd, input logic [31:0] wdata, input logic pcv,
                        input logic [31:0] pc, input logic jump, input logic [31:0] tgt,
                        input logic trap);
        bus.in_valid    = 1'b1;
        bus.in_insn     = insn;
        bus.in_rs1      = rs1;
        bus.in_rs2      = rs2;
        bus.in_rd       = rd;
        bus.in_rd_wdata = wdata;
        bus.in_pc_valid = pcv;
        bus.in_pc       = pc;
        bus.in_jump     = jump;
        bus.in_target   = tgt;
        bus.in_trap     = trap;
        @(negedge clk);
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
        @(negedge clk);
    endtask

    // Release reset on the current falling edge and walk the 32 clear cycles.
    task automatic wait_clear();
        reset = 1'b0;
        for (int i = 0; i < 32; i++) begin
            chk("clear_ready", bus.in_ready, 0);
            chk("clear_valid", bus.rvfi_valid, 0);
            @(negedge clk);
        end
        chk("run_ready", bus.in_ready, 1);
    endtask

    initial begin
        reset           = 1'b1;
        bus.in_valid    = 1'b1;
        bus.in_insn     = 32'h13;
        bus.in_rs1      = 5'd0;
        bus.in_rs2      = 5'd0;
        bus.in_rd       = 5'd1;
        bus.in_rd_wdata = 32'h55;
        bus.in_pc_valid = 1'b0;
        bus.in_pc       = '0;
        bus.in_jump     = 1'b0;
        bus.in_target   = '0;
        bus.in_trap     = 1'b0;
`ifdef RVFI_DRIVER_FAULT_EN
        fault_inj       = 2'd0;
`endif
        @(negedge clk);
        chk("rst_order", bus.rvfi_order, 0);
        chk("rst_post_pc", bus.rvfi_post_pc, 0);
        wait_clear();

        // A: 32-bit insn writes x5
        send(32'h0000_0013, 5'd0, 5'd0, 5'd5, 32'hDEAD_BEEF, 1'b0, 0, 1'b0, 0, 1'b0);
        chk("A_valid", bus.rvfi_valid, 1);
        chk("A_order", bus.rvfi_order, 0);
        chk("A_pre_pc", bus.rvfi_pre_pc, 32'h100);
        chk("A_post_pc", bus.rvfi_post_pc, 32'h104);
        chk("A_rd", bus.rvfi_rd, 5);
        chk("A_post_rd", bus.rvfi_post_rd, 32'hDEAD_BEEF);
        chk("A_insn", bus.rvfi_insn, 32'h13);
        chk("mem_wmask", bus.rvfi_mem_wmask, 0);
        chk("mem_addr", bus.rvfi_mem_addr, 0);

        // B: compressed, back-to-back read of x5, write to x0 ignored
        send(32'h0000_4501, 5'd5, 5'd0, 5'd0, 32'h7, 1'b0, 0, 1'b0, 0, 1'b0);
        chk("B_valid", bus.rvfi_valid, 1);
        chk("B_order", bus.rvfi_order, 1);
        chk("B_pre_rs1", bus.rvfi_pre_rs1, 32'hDEAD_BEEF);
        chk("B_pre_rs2", bus.rvfi_pre_rs2, 0);
        chk("B_rs1_addr", bus.rvfi_rs1_addr, 5);
        chk("B_pre_pc", bus.rvfi_pre_pc, 32'h104);
        chk("B_post_pc", bus.rvfi_post_pc, 32'h106);
        chk("B_rd_x0", bus.rvfi_rd, 0);
        chk("B_post_rd_x0", bus.rvfi_post_rd, 0);

        // C: jump to 0x40, link into x1
        send(32'h0000_006F, 5'd0, 5'd0, 5'd1, 32'h10A, 1'b0, 0, 1'b1, 32'h40, 1'b0);
        chk("C_pre_pc", bus.rvfi_pre_pc, 32'h106);
        chk("C_post_pc", bus.rvfi_post_pc, 32'h40);
        chk("C_order", bus.rvfi_order, 2);

        idle();
        chk("idle_valid", bus.rvfi_valid, 0);
        chk("hold_order", bus.rvfi_order, 2);
        chk("hold_post_pc", bus.rvfi_post_pc, 32'h40);

        // D: trap with rd=3 must not write
        send(32'h0000_0073, 5'd1, 5'd5, 5'd3, 32'h9, 1'b0, 0, 1'b0, 0, 1'b1);
        chk("D_pre_pc", bus.rvfi_pre_pc, 32'h40);
        chk("D_post_pc", bus.rvfi_post_pc, 32'h40);
        chk("D_trap", bus.rvfi_trap, 1);
        chk("D_rd", bus.rvfi_rd, 0);
        chk("D_post_rd", bus.rvfi_post_rd, 0);
        chk("D_pre_rs1", bus.rvfi_pre_rs1, 32'h10A);
        chk("D_pre_rs2", bus.rvfi_pre_rs2, 32'hDEAD_BEEF);
        chk("D_order", bus.rvfi_order, 3);

        // E: explicit PC, read x3 (untouched) and x2 while writing x2
        send(32'h0000_0013, 5'd3, 5'd2, 5'd2, 32'h10, 1'b1, 32'h200, 1'b0, 0, 1'b0);
        chk("E_pre_pc", bus.rvfi_pre_pc, 32'h200);
        chk("E_post_pc", bus.rvfi_post_pc, 32'h204);
        chk("E_pre_rs1_x3", bus.rvfi_pre_rs1, 0);
        chk("E_pre_rs2_old", bus.rvfi_pre_rs2, 0);
        chk("E_trap", bus.rvfi_trap, 0);

`ifdef RVFI_DRIVER_FAULT_EN
        fault_inj = 2'd1;
`endif
        send(32'h0000_0013, 5'd2, 5'd0, 5'd0, 32'h0, 1'b0, 0, 1'b0, 0, 1'b0);
`ifdef RVFI_DRIVER_FAULT_EN
        chk("F_pre_rs1", bus.rvfi_pre_rs1, 32'h11);
        fault_inj = 2'd3;
`else
        chk("F_pre_rs1", bus.rvfi_pre_rs1, 32'h10);
`endif
        chk("F_pre_pc", bus.rvfi_pre_pc, 32'h204);
        send(32'h0000_0013, 5'd0, 5'd0, 5'd4, 32'h5, 1'b0, 0, 1'b0, 0, 1'b0);
        chk("F2_rd", bus.rvfi_rd, 4);
        chk("F2_post_rd", bus.rvfi_post_rd, 5);
`ifdef RVFI_DRIVER_FAULT_EN
        fault_inj = 2'd0;
`endif
        send(32'h0000_0013, 5'd4, 5'd0, 5'd0, 32'h0, 1'b0, 0, 1'b0, 0, 1'b0);
`ifdef RVFI_DRIVER_FAULT_EN
        chk("G_pre_rs1", bus.rvfi_pre_rs1, 0);
`else
        chk("G_pre_rs1", bus.rvfi_pre_rs1, 5);
`endif
        chk("G_pre_pc", bus.rvfi_pre_pc, 32'h20C);
        chk("G_order", bus.rvfi_order, 7);

        // 256 records with a gap after every fourth: order wraps 255 -> 0
        for (int i = 0; i < 256; i++) begin
            send(32'h0000_0013, 5'd0, 5'd0, 5'd0, 32'h0, 1'b0, 0, 1'b0, 0, 1'b0);
            chk("loop_valid", bus.rvfi_valid, 1);
            chk("loop_order", bus.rvfi_order, (8 + i) % 256);
            if (i % 4 == 3) begin
                idle();
                chk("gap_valid", bus.rvfi_valid, 0);
            end
        end

        // Reset mid-stream drops the accepted packet and re-clears the RF
        bus.in_valid    = 1'b1;
        bus.in_rd       = 5'd5;
        bus.in_rd_wdata = 32'h1;
        reset           = 1'b1;
        @(negedge clk);
        chk("mrst_valid", bus.rvfi_valid, 0);
        chk("mrst_order", bus.rvfi_order, 0);
        chk("mrst_insn", bus.rvfi_insn, 0);
        chk("mrst_ready", bus.in_ready, 0);
        wait_clear();
        send(32'h0000_0013, 5'd5, 5'd1, 5'd0, 32'h0, 1'b0, 0, 1'b0, 0, 1'b0);
        chk("R_pre_rs1", bus.rvfi_pre_rs1, 0);
        chk("R_pre_rs2", bus.rvfi_pre_rs2, 0);
        chk("R_order", bus.rvfi_order, 0);
        chk("R_pre_pc", bus.rvfi_pre_pc, 32'h100);
        idle();
        chk("R_idle_valid", bus.rvfi_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/rvfi_reg_trace_driver.md
# rvfi_reg_trace_driver

Transmit-side driver for the single-channel RVFI retirement interface in formal and simulation harnesses. It accepts abstract retirement records through a valid/ready handshake, keeps its own 32-entry architectural register file, and emits fully populated RVFI packets whose `rvfi_pre_rs1`/`rvfi_pre_rs2` values are consistent with all earlier `rvfi_rd`/`rvfi_post_rd` writes. It is the stimulus source for register-consistency checkers and for trace-replay benches, with no CPU core attached.

## Interface
- `XLEN`, 32, register and PC width: 32 or 64.
- `RESET_PC`, 0, PC assumed for the first record after reset when `in_pc_valid` = 0.
- `clk`  in  1  clock; all logic is on the rising edge.
- `reset`  in  1  synchronous reset, active-high.
- `in_valid`  in  1  record present.
- `in_ready`  out  1  record accepted on a cycle where `in_valid && in_ready`.
- `in_insn`  in  32  instruction word.
- `in_rs1`, `in_rs2`, `in_rd`  in  5 each  register indices.
- `in_rd_wdata`  in  XLEN  value written to `rd`.
- `in_pc_valid`  in  1  when 1, `in_pc` overrides the tracked PC.
- `in_pc`  in  XLEN  explicit PC.
- `in_jump`  in  1  when 1, the next PC is `in_target`.
- `in_target`  in  XLEN  jump target.
- `in_trap`  in  1  instruction traps; no register write.
- `fault_inj`  in  2  fault-injection select. Present only with `RVFI_DRIVER_FAULT_EN`.
- `rvfi_valid`  out  1; `rvfi_order`  out  8; `rvfi_insn`  out  32; `rvfi_rs1_addr`, `rvfi_rs2_addr`, `rvfi_rd`  out  5; `rvfi_pre_pc`, `rvfi_pre_rs1`, `rvfi_pre_rs2`, `rvfi_post_pc`, `rvfi_post_rd`  out  XLEN; `rvfi_trap`  out  1; `rvfi_mem_addr`, `rvfi_mem_rdata`, `rvfi_mem_wdata`  out  XLEN; `rvfi_mem_rmask`, `rvfi_mem_wmask`  out  XLEN/8.

## Operation
- FSM states: CLEAR and RUN.
- **Reset** enters CLEAR, with a 5-bit clear index at 0, tracked PC = `RESET_PC`, order = 0.
- **CLEAR**
  - Writes 0 to register-file entry `idx` each cycle.
  - Lasts 32 cycles, then moves to RUN.
  - `in_ready` = 0 throughout.
- **RUN**
  - `in_ready` = 1.
  - On accept, the next-cycle outputs are:
    - `rvfi_valid` = 1.
    - `rvfi_insn`, `rvfi_rs1_addr`, `rvfi_rs2_addr` from the record.
    - `rvfi_pre_pc` = `in_pc` if `in_pc_valid`, else the tracked PC.
    - `rvfi_pre_rs1` = RF[`in_rs1`], forced to 0 when `in_rs1` = 0. `rvfi_pre_rs2` likewise.
    - `rvfi_rd`/`rvfi_post_rd` = `in_rd`/`in_rd_wdata` only when `!in_trap && in_rd != 0`; otherwise both are 0.
    - `rvfi_post_pc`, chosen in this order:
      - `in_target` if `in_jump`;
      - `pre_pc` if `in_trap`;
      - `pre_pc + 2` if `in_insn[1:0] != 2'b11`;
      - otherwise `pre_pc + 4`.
      - Arithmetic is modulo 2^XLEN.
    - `rvfi_trap` = `in_trap`.
    - `rvfi_order` = the order counter, which then increments and wraps 255→0.
  - On the same edge, RF[`in_rd`] is written when the write condition above holds, and the tracked PC becomes `rvfi_post_pc`.
  - Back-to-back dependency: the write takes effect at the accept edge, so a record accepted the next cycle reads the new value. No bypass is needed; combinational RF read is required.
- `rvfi_mem_*` are constantly 0. The driver produces register-only traces.
- **Reset mid-stream:** the packet in flight is dropped (`rvfi_valid` = 0 the next cycle), the RF is re-cleared, and the order restarts at 0.

## Timing
- Latency: exactly 1 cycle from the accept edge to `rvfi_valid` = 1.
- Throughput: one record per cycle in RUN.
- `rvfi_valid` = 0 on any cycle after an edge with no accept.
- Output hold: all `rvfi_*` outputs other than `rvfi_valid` hold their last values when idle.
- Reset values of all outputs: 0. `in_ready` = 0.
- First possible accept: 32 cycles after `reset` deasserts, so the first `rvfi_valid` is on cycle 33.

## Configuration
- `RVFI_DRIVER_FAULT_EN`
  - **Defined:** port `fault_inj` exists and is sampled on accept.
    - 1 = XOR bit 0 of `rvfi_pre_rs1` when `in_rs1 != 0`.
    - 2 = XOR bit 0 of `rvfi_pre_rs2` when `in_rs2 != 0`.
    - 3 = suppress the RF write while still reporting `rvfi_rd`/`rvfi_post_rd`.
    - 0 = normal operation.
  - **Undefined:** the port is absent and behaviour is always fault-free.
  - Purpose: proves that downstream checkers fire.

## Test plan
- **Reset/clear:** pulse `reset` for 1 cycle with `in_valid` = 1 → `in_ready` = 0 for 32 cycles, and `rvfi_valid` stays 0 until the first accept.
- **Write then read:** record A (`rd`=5, wdata=0xDEADBEEF), then B (`rs1`=5, `rs2`=0) back-to-back → B shows `pre_rs1`=0xDEADBEEF, `pre_rs2`=0, and orders 0 and 1.
- **x0 and trap:** `rd`=0 with wdata=7 → `rvfi_rd`=0, `post_rd`=0. A trap with `rd`=3 and wdata=9 → `rvfi_rd`=0, `post_pc`=`pre_pc`, and a later read of x3 returns its old value.
- **PC tracking:** `RESET_PC`=0x100; a 32-bit insn, a compressed insn (`insn[1:0]`=2'b01), then a jump to 0x40 → `pre_pc` sequence 0x100, 0x104, 0x106, and the next `pre_pc` is 0x40.
- **Order wrap and gaps:** 256 records with idle cycles interleaved → orders run 0..255 then 0, and `rvfi_valid` = 0 on the idle cycles.
- **Fault (with `RVFI_DRIVER_FAULT_EN`):** x2=0x10, then `fault_inj`=1 reading `rs1`=2 → `pre_rs1`=0x11. With `fault_inj`=3 writing x4=5, a later read of x4 returns 0.
